uart_r: RTL and testbench

- Serial receiver stage directly downstream of the UART transmitter (UART_T).
- Frame format: line idles high, one start bit (0), then D_WIDTH data bits LSB first, then one stop bit (1).
- Synchronises the rx line, finds the start bit and samples every bit at mid-bit.
- Delivers each word through a one-entry valid/ready holding register, with framing-error and overrun pulses.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_r.sv | 115 +++++++++++
 tb/tb_uart_r.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART word width, receiver state encoding and line-level bit constants.
package uart_pkg;
  localparam int D_WIDTH = 14;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: STAGES-deep flop chain for the rx line, reset to the idle level (1).
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s_o
);
  if (STAGES == 0) begin : g_bypass
    assign rx_s_o = rx_i;
  end else begin : g_chain
    logic [STAGES-1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '1;
      end else begin
        sync_q[0] <= rx_i;
        for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign rx_s_o = sync_q[STAGES-1];
  end
endmodule

// File: rtl/uart_r.sv
// uart_r: UART receiver with mid-bit sampling, a one-entry valid/ready holding register,
// and framing-error / overrun pulses.
module uart_r
  import uart_pkg::*;
#(
  parameter int D_WIDTH      = uart_pkg::D_WIDTH,
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               rx_busy,
  output logic               frame_err,
  output logic               overrun
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int PW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(D_WIDTH + 1);
  localparam logic [PW-1:0] PH_HALF = PW'(HALF);
  localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(D_WIDTH - 1);

  logic rx_s;
  rx_state_e state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [D_WIDTH-1:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d, done;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_i  (rx),
    .rx_s_o(rx_s)
  );

  // Phase counter counts up to the next sample; it restarts at 0 right after each sample.
  always_comb begin
    state_d = state_q;
    ph_d = ph_q;
    bit_d = bit_q;
    sh_d = sh_q;
    done = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      IDLE: if (rx_s == START_BIT) begin
        state_d = (HALF == 0) ? DATA : START;
        ph_d = (HALF == 0) ? '0 : PW'(1);
      end
      START: if (ph_q == PH_HALF) begin
        state_d = (rx_s == START_BIT) ? DATA : IDLE;
        ph_d = '0;
      end else begin
        ph_d = ph_q + 1'b1;
      end
      DATA: if (ph_q == PH_LAST) begin
        ph_d = '0;
        sh_d = {rx_s, sh_q[D_WIDTH-1:1]};
        bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        state_d = (bit_q == BIT_LAST) ? STOP : DATA;
      end else begin
        ph_d = ph_q + 1'b1;
      end
      STOP: if (ph_q == PH_LAST) begin
        ph_d = '0;
        done = (rx_s == STOP_BIT);
        ferr_d = (rx_s != STOP_BIT);
        state_d = (rx_s == STOP_BIT) ? IDLE : BREAK;
      end else begin
        ph_d = ph_q + 1'b1;
      end
      BREAK: state_d = (rx_s == STOP_BIT) ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end

  // A completing word replaces the held one only if that one is leaving this same edge.
  always_comb begin
    valid_d = done | (valid_q & ~rx_ready);
    data_d = (done && (!valid_q || rx_ready)) ? sh_q : data_q;
    ovr_d = done & valid_q & ~rx_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
  end

  assign rx_data = data_q;
  assign rx_valid = valid_q;
  assign rx_busy = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign frame_err = ferr_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_uart_r.sv
// tb_uart_r: drives one rx line into a CLKS_PER_BIT=1 and a CLKS_PER_BIT=4 receiver and checks
// both every cycle against a frame-timing model, plus directed literal expectations.
module tb_uart_r;
  localparam int D = 14;
  localparam int SY = 2;

  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rx_ready = 1'b1;
  logic [D-1:0] dd[2];
  logic dv[2], db[2], dfe[2], dov[2];

  always #5 clk = ~clk;

  uart_r #(.D_WIDTH(D), .CLKS_PER_BIT(1), .SYNC_STAGES(SY)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(dd[0]), .rx_valid(dv[0]), .rx_ready(rx_ready),
    .rx_busy(db[0]), .frame_err(dfe[0]), .overrun(dov[0])
  );
  uart_r #(.D_WIDTH(D), .CLKS_PER_BIT(4), .SYNC_STAGES(SY)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(dd[1]), .rx_valid(dv[1]), .rx_ready(rx_ready),
    .rx_busy(db[1]), .frame_err(dfe[1]), .overrun(dov[1])
  );

  int nchk = 0, nerr = 0, n = 0;
  int cpb[2] = '{1, 4};
  int mode[2], t0[2];
  logic [D-1:0] e_data[2];
  logic e_valid[2], e_busy[2], e_fe[2], e_ov[2];
  logic rxh[0:4095];
  int vc0[$], vc1[$], fc[2], oc[2];
  logic [D-1:0] vd0[$], vd1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, n);
    end
  endtask

  // Model: mode 0 free, 1 inside a frame (t0 = first cycle rx_s seen low), 2 waiting after a bad stop.
  always @(negedge clk) begin : model
    int c, h;
    logic rs, done, fe;
    logic [D-1:0] w;
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        mode[u] = 0;
        e_data[u] = '0;
        e_valid[u] = 1'b0;
        e_busy[u] = 1'b0;
        e_fe[u] = 1'b0;
        e_ov[u] = 1'b0;
      end
    end
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_data", u), 32'(dd[u]), 32'(e_data[u]));
      chk($sformatf("u%0d_valid", u), 32'(dv[u]), 32'(e_valid[u]));
      chk($sformatf("u%0d_busy", u), 32'(db[u]), 32'(e_busy[u]));
      chk($sformatf("u%0d_frame_err", u), 32'(dfe[u]), 32'(e_fe[u]));
      chk($sformatf("u%0d_overrun", u), 32'(dov[u]), 32'(e_ov[u]));
      if (dfe[u]) fc[u]++;
      if (dov[u]) oc[u]++;
    end
    if (dv[0]) begin vc0.push_back(n); vd0.push_back(dd[0]); end
    if (dv[1]) begin vc1.push_back(n); vd1.push_back(dd[1]); end
    rxh[n] = rst_n ? rx : 1'b1;
    if (rst_n) begin
      for (int u = 0; u < 2; u++) begin
        c = cpb[u];
        h = (c - 1) / 2;
        rs = (n >= SY) ? rxh[n-SY] : 1'b1;
        done = 1'b0;
        fe = 1'b0;
        w = '0;
        if (mode[u] == 2) begin
          if (rs) mode[u] = 0;
        end else if (mode[u] == 0) begin
          if (!rs) begin t0[u] = n; mode[u] = 1; end
        end else if (n == t0[u] + h && rs) begin
          mode[u] = 0;
        end else if (n == t0[u] + (D + 1) * c + h) begin
          for (int k = 0; k < D; k++) w[k] = rxh[t0[u] + (k + 1) * c + h - SY];
          done = rs;
          fe = !rs;
          mode[u] = rs ? 0 : 2;
        end
        e_ov[u] = done && e_valid[u] && !rx_ready;
        if (done && (!e_valid[u] || rx_ready)) e_data[u] = w;
        e_valid[u] = done || (e_valid[u] && !rx_ready);
        e_fe[u] = fe;
        e_busy[u] = (mode[u] == 1);
      end
    end
    n++;
  end

  task automatic cyc(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask
  task automatic bitc(input logic b, input int c);
    rx = b;
    cyc(c);
  endtask
  task automatic idle(input int k);
    bitc(1'b1, k);
  endtask
  task automatic frame(input logic [D-1:0] wd, input int c, input logic stopb);
    bitc(1'b0, c);
    for (int k = 0; k < D; k++) bitc(wd[k], c);
    bitc(stopb, c);
  endtask
  task automatic clr();
    vc0.delete(); vc1.delete(); vd0.delete(); vd1.delete();
    fc = '{0, 0};
    oc = '{0, 0};
  endtask

  initial begin
    int s;
    cyc(3);
    chk("rst_valid", 32'(dv[0]), 0);
    chk("rst_data", 32'(dd[0]), 0);
    chk("rst_busy", 32'(db[0]), 0);
    chk("rst_flags", 32'({dfe[0], dov[0]}), 0);
    rst_n = 1'b1;
    idle(10);

    clr(); s = n;
    frame(14'h1A5C, 1, 1'b1);
    idle(40);
    chk("t1_count", vc0.size(), 1);
    if (vc0.size() >= 1) begin
      chk("t1_latency", vc0[0] - s, 18);
      chk("t1_data", 32'(vd0[0]), 32'h1A5C);
    end
    chk("t1_flags", fc[0] + oc[0], 0);

    clr(); s = n;
    frame(14'h3FFF, 1, 1'b1);
    frame(14'h0000, 1, 1'b1);
    idle(60);
    chk("t2_count", vc0.size(), 2);
    if (vc0.size() >= 2) begin
      chk("t2_latency", vc0[0] - s, 18);
      chk("t2_gap", vc0[1] - vc0[0], 16);
      chk("t2_data0", 32'(vd0[0]), 32'h3FFF);
      chk("t2_data1", 32'(vd0[1]), 32'h0000);
    end

    clr();
    frame(14'h0001, 1, 1'b0);
    bitc(1'b0, 5);
    bitc(1'b1, 1);
    s = n;
    frame(14'h0002, 1, 1'b1);
    idle(60);
    chk("t3_frame_err", fc[0], 1);
    chk("t3_count", vc0.size(), 1);
    if (vc0.size() >= 1) begin
      chk("t3_latency", vc0[0] - s, 18);
      chk("t3_data", 32'(vd0[0]), 32'h0002);
    end

    clr();
    rx_ready = 1'b0;
    frame(14'h0123, 1, 1'b1);
    idle(3);
    frame(14'h0456, 1, 1'b1);
    idle(25);
    chk("t4_valid", 32'(dv[0]), 1);
    chk("t4_data", 32'(dd[0]), 32'h0123);
    chk("t4_overrun", oc[0], 1);
    rx_ready = 1'b1;
    cyc(2);
    chk("t4_drained", 32'(dv[0]), 0);
    idle(100);

    clr();
    bitc(1'b0, 1);
    idle(20);
    chk("t5_glitch_valid", vc1.size(), 0);
    chk("t5_glitch_flags", fc[1] + oc[1], 0);
    chk("t5_glitch_busy", 32'(db[1]), 0);
    s = n;
    frame(14'h2AAA, 4, 1'b1);
    idle(80);
    chk("t5_count", vc1.size(), 1);
    if (vc1.size() >= 1) begin
      chk("t5_latency", vc1[0] - s, 64);
      chk("t5_data", 32'(vd1[0]), 32'h2AAA);
    end
    chk("t5_flags", fc[1] + oc[1], 0);

    clr();
    bitc(1'b0, 1);
    for (int k = 0; k < 6; k++) bitc(k == 2 || k == 4 || k == 5, 1);
    chk("t6_busy_before", 32'(db[0]), 1);
    rx = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_busy_async", 32'(db[0]), 0);
    chk("t6_valid_async", 32'(dv[0]), 0);
    chk("t6_data_async", 32'(dd[0]), 0);
    cyc(3);
    rst_n = 1'b1;
    idle(40);
    chk("t6_no_valid", vc0.size(), 0);
    s = n;
    frame(14'h1234, 1, 1'b1);
    idle(40);
    chk("t6_count", vc0.size(), 1);
    if (vc0.size() >= 1) begin
      chk("t6_latency", vc0[0] - s, 18);
      chk("t6_data", 32'(vd0[0]), 32'h1234);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
